snn_cfg_sequencer: RTL
======================

SNN_CFG_SEQUENCER -- requirements
Module: snn_cfg_sequencer

Interface
REQ-001 SHALL have parameter DELAY_DIV, default 4, meaning clk cycles per delay_clk tick (legal range 2..255).
REQ-002 SHALL have parameter CLR_CYCLES, default 2, meaning net_reset pulse length in cycles (legal range 1..15).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_start  in  1  begin a configuration load and restart at byte 0.
REQ-006 cfg_valid  in  1  cfg_data holds a valid byte.
REQ-007 cfg_data  in  8  configuration byte.
REQ-008 cfg_ready  out  1  byte accepted when cfg_valid and cfg_ready are both high.
REQ-009 run_req / stop_req  in  1 each  start / stop network execution.
REQ-010 weights  out  1152  packed weights for both network layers.
REQ-011 delays  out  576  packed delay fields, 4 bits per synapse.
REQ-012 threshold, decay, refractory_period  out  8 each  neuron parameters.
REQ-013 net_reset  out  1  active-high reset to the network.
REQ-014 net_enable  out  1  network enable.
REQ-015 delay_clk  out  1  one-cycle delay-tick strobe.
REQ-016 cfg_done  out  1  complete configuration present.
REQ-017 state  out  2  current state: IDLE=0, LOAD=1, CLEAR=2, RUN=3.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM IDLE: cfg_start->LOAD; else run_req with cfg_done=1->CLEAR; cfg_start beats run_req; run_req with cfg_done=0 ignored; stop_req ignored.
REQ-020 On entering LOAD: byte address cleared to 0 and cfg_done cleared.
REQ-021 cfg_ready SHALL be 1 exactly while state=LOAD.
REQ-022 Byte address map, one byte per accepted handshake, address incremented per handshake:
- addr k, 0..143: weights[8k+7:8k]
- addr 144..215: delays[8(k-144)+7:8(k-144)]
- 216: threshold; 217: decay; 218: refractory_period
REQ-023 Handshake at addr 218: next state IDLE, cfg_done=1 next cycle; no wrap to 0.
REQ-024 cfg_start asserted during LOAD SHALL restart at addr 0; already-written bytes retained until overwritten.
REQ-025 Configuration registers SHALL change only on LOAD handshakes.
REQ-026 cfg_valid outside LOAD SHALL be ignored.
REQ-027 CLEAR:
- net_reset=1 for exactly CLR_CYCLES cycles, net_enable=0.
- Then RUN.
- run_req, stop_req and cfg_start ignored.
REQ-028 RUN:
- net_enable=1.
- Tick counter starts at 0 on entry, increments each cycle, wraps at DELAY_DIV-1.
- delay_clk=1 in the cycle the counter equals DELAY_DIV-1, so the first strobe is the DELAY_DIV-th RUN cycle, then every DELAY_DIV cycles.
REQ-029 stop_req in RUN (wins over simultaneous run_req):
- Next cycle: IDLE, net_enable=0, delay_clk=0.
- Counter cleared.
- cfg_done kept.
REQ-030 cfg_start in RUN SHALL be ignored; reconfiguration requires stop first.

Reset
REQ-031 On reset_n low, asynchronously:
- state=IDLE.
- All configuration outputs=0; cfg_done, cfg_ready, net_enable, delay_clk=0.
- net_reset=1 while reset_n low, 0 from the first clock edge after release.
- Address and counters=0.
REQ-032 Reset mid-LOAD or mid-RUN SHALL abort the operation with no partial completion flag.

Structure
REQ-033 Shared package snn_cfg_pkg SHALL hold:
- the state encoding;
- N_WEIGHT_BYTES=144, N_DELAY_BYTES=72, N_CFG_BYTES=219;
- base addresses 0, 144, 216, 217, 218.
REQ-034 The tick generator SHALL be a sub-module snn_tick_divider (inputs clear, run; output strobe).

Verification
REQ-035 Load bytes 0..218 with data=addr[7:0] and cfg_valid held high -> 219 accepted cycles, weights[7:0]=0x00, delays[7:0]=0x90, threshold=0xD8, decay=0xD9, refractory_period=0xDA, cfg_done=1, state=IDLE.
REQ-036 run_req after load -> net_reset high exactly 2 cycles, then net_enable=1, with delay_clk pulses on RUN cycles 4, 8, 12.
REQ-037 run_req with cfg_done=0 -> state stays IDLE, net_reset=0, net_enable=0.
REQ-038 run_req and stop_req together in RUN -> IDLE next cycle, net_enable=0, no further delay_clk.
REQ-039 Load 100 bytes, pulse cfg_start, load 219 bytes of 0xFF -> all configuration outputs all-ones, cfg_done=1 only after the final byte.
REQ-040 reset_n low mid-LOAD at addr 50 -> all outputs 0 immediately, net_reset=1, state=IDLE, cfg_done=0.

Source files
------------

// File: rtl/snn_cfg_pkg.sv
// rtl/snn_cfg_pkg.sv - shared state encoding and configuration byte map for the SNN sequencer
package snn_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int N_WEIGHT_BYTES = 144;
    localparam int N_DELAY_BYTES  = 72;
    localparam int N_CFG_BYTES    = 219;

    localparam int WEIGHT_BITS = 8 * N_WEIGHT_BYTES;
    localparam int DELAY_BITS  = 8 * N_DELAY_BYTES;

    localparam logic [7:0] WEIGHT_BASE     = 8'd0;
    localparam logic [7:0] DELAY_BASE      = 8'd144;
    localparam logic [7:0] THRESHOLD_ADDR  = 8'd216;
    localparam logic [7:0] DECAY_ADDR      = 8'd217;
    localparam logic [7:0] REFRACTORY_ADDR = 8'd218;

endpackage

// File: rtl/snn_cfg_sequencer_if.sv
// rtl/snn_cfg_sequencer_if.sv - configuration byte stream handshake between host and sequencer
interface snn_cfg_sequencer_if;
    import snn_cfg_pkg::*;

    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;

    modport master (output cfg_start, output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_start, input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/snn_tick_divider.sv
// rtl/snn_tick_divider.sv - registered one-cycle strobe every DIV cycles while run is high
module snn_tick_divider
    import snn_cfg_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic strobe
);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == 8'(DIV - 1)) ? 8'd0 : cnt + 8'd1;
    end

    // strobe is registered from the look-ahead count so it lines up with cnt == DIV-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 8'd0;
            strobe <= 1'b0;
        end else if (clear || !run) begin
            cnt    <= 8'd0;
            strobe <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            strobe <= (cnt_nxt == 8'(DIV - 1));
        end
    end

endmodule

// File: rtl/snn_cfg_sequencer.sv
// rtl/snn_cfg_sequencer.sv - loads SNN configuration bytes, then sequences network clear and run
module snn_cfg_sequencer
    import snn_cfg_pkg::*;
#(
    parameter int DELAY_DIV  = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    snn_cfg_sequencer_if.slave     cfg,
    input  logic                   run_req,
    input  logic                   stop_req,
    output logic [WEIGHT_BITS-1:0] weights,
    output logic [DELAY_BITS-1:0]  delays,
    output logic [7:0]             threshold,
    output logic [7:0]             decay,
    output logic [7:0]             refractory_period,
    output logic                   net_reset,
    output logic                   net_enable,
    output logic                   delay_clk,
    output logic                   cfg_done,
    output logic [1:0]             state
);

    localparam logic [7:0] LAST_ADDR = 8'(N_CFG_BYTES - 1);

    state_t     st, st_nxt;
    logic [7:0] addr;
    logic [7:0] woff;
    logic [6:0] doff;
    logic [3:0] clr_cnt;
    logic       hs, last_byte, enter_load;

    assign hs         = cfg.cfg_valid && cfg.cfg_ready;
    assign last_byte  = hs && (addr == LAST_ADDR);
    assign enter_load = cfg.cfg_start && (st == ST_IDLE || st == ST_LOAD);
    assign woff       = addr - WEIGHT_BASE;
    assign doff       = 7'(addr - DELAY_BASE);
    assign state      = st;

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:  if (cfg.cfg_start) st_nxt = ST_LOAD;
                      else if (run_req && cfg_done) st_nxt = ST_CLEAR;
            ST_LOAD:  if (last_byte && !cfg.cfg_start) st_nxt = ST_IDLE;
            ST_CLEAR: if (clr_cnt == 4'(CLR_CYCLES - 1)) st_nxt = ST_RUN;
            ST_RUN:   if (stop_req) st_nxt = ST_IDLE;
            default:  st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= ST_IDLE;
        else          st <= st_nxt;
    end

    // Status outputs are registered from the next state so they align with state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= 8'd0;
            clr_cnt       <= 4'd0;
            cfg_done      <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            net_reset     <= 1'b1;
            net_enable    <= 1'b0;
        end else begin
            cfg.cfg_ready <= (st_nxt == ST_LOAD);
            net_reset     <= (st_nxt == ST_CLEAR);
            net_enable    <= (st_nxt == ST_RUN);
            clr_cnt       <= (st == ST_CLEAR) ? clr_cnt + 4'd1 : 4'd0;
            if (enter_load)            addr <= 8'd0;
            else if (hs && !last_byte) addr <= addr + 8'd1;
            if (enter_load)            cfg_done <= 1'b0;
            else if (last_byte)        cfg_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            weights           <= '0;
            delays            <= '0;
            threshold         <= 8'd0;
            decay             <= 8'd0;
            refractory_period <= 8'd0;
        end else if (hs) begin
            if (addr < DELAY_BASE)           weights[{woff, 3'b000} +: 8] <= cfg.cfg_data;
            else if (addr < THRESHOLD_ADDR)  delays[{doff, 3'b000} +: 8]  <= cfg.cfg_data;
            else if (addr == THRESHOLD_ADDR) threshold                    <= cfg.cfg_data;
            else if (addr == DECAY_ADDR)     decay                        <= cfg.cfg_data;
            else if (addr == REFRACTORY_ADDR) refractory_period           <= cfg.cfg_data;
        end
    end

    snn_tick_divider #(.DIV(DELAY_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   ((st == ST_RUN) && stop_req),
        .run     (st == ST_RUN),
        .strobe  (delay_clk)
    );

endmodule
